// File: rtl/vfm_io_pkg.sv
// Shared definitions for the VFM switch-to-core input writer:
// FSM state encoding, default core input-port width and In_data field positions.
package vfm_io_pkg;

    localparam int IN_WIDTH_DEF = 14;

    // In_data field layout
    localparam int VALID_BIT = 0;
    localparam int NIB_LSB   = 1;
    localparam int NIB_MSB   = 4;
    localparam int TAG_LSB   = 5;
    localparam int TAG_WIDTH = 9;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        ISSUE      = 3'd2,
        HELD       = 3'd3,
        RELEASE_DB = 3'd4
    } vfm_state_t;

endpackage

// File: rtl/vfm_sync2.sv
// Parameterized-width two-flop synchronizer. Both stages reset to all-ones so
// an idle (released, active-low) button reads as not pressed during reset.
module vfm_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vfm_input_writer.sv
// Debounced push-button writer for the VFM core input port In0.
// SW_in[4] is an active-low write button, SW_in[3:0] the data nibble. Each
// accepted press emits one single-cycle Input_write with In_data =
// {tag/zeros, nibble, 1'b1}.
// Optional build macro: VFM_INPUT_SEQ_TAG_EN adds a 9-bit wrapping sequence
// tag in In_data[13:5] (requires IN_WIDTH >= 14).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | button released and debounced; waiting for a low strobe
// PRESS_DB   | strobe low; counting stable low cycles before accepting
// ISSUE      | one cycle: Input_write high, In_data freshly loaded
// HELD       | press accepted; waiting for the button to go high
// RELEASE_DB | strobe high; counting stable high cycles before re-arming
module vfm_input_writer
    import vfm_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int IN_WIDTH        = IN_WIDTH_DEF
) (
    input  logic                Clock_pin,
    input  logic                Resetn_pin,
    input  logic [4:0]          SW_in,
    output logic [IN_WIDTH-1:0] In_data,
    output logic                Input_write,
    output logic                Busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]          sw_sync;
    logic                strobe;
    vfm_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [IN_WIDTH-1:0] issue_word;
`ifdef VFM_INPUT_SEQ_TAG_EN
    logic [TAG_WIDTH-1:0] seq_tag;
`endif

    vfm_sync2 #(
        .WIDTH (5)
    ) u_sync (
        .clk   (Clock_pin),
        .rst_n (Resetn_pin),
        .d     (SW_in),
        .q     (sw_sync)
    );

    assign strobe = sw_sync[4];

    // Saturating increment: the counter parks at its last value instead of wrapping
    always_comb begin
        cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);
    end

    // Word captured on the edge entering ISSUE
    always_comb begin
        issue_word                   = '0;
        issue_word[VALID_BIT]        = 1'b1;
        issue_word[NIB_MSB:NIB_LSB]  = sw_sync[3:0];
`ifdef VFM_INPUT_SEQ_TAG_EN
        issue_word[TAG_LSB +: TAG_WIDTH] = seq_tag;
`endif
    end

    // Debounce/issue FSM with registered outputs
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            state       <= IDLE;
            cnt         <= '0;
            In_data     <= '0;
            Input_write <= 1'b0;
            Busy        <= 1'b0;
`ifdef VFM_INPUT_SEQ_TAG_EN
            seq_tag     <= '0;
`endif
        end else begin
            Input_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (!strobe) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (strobe) begin
                        state <= IDLE;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= ISSUE;
                        cnt         <= '0;
                        Input_write <= 1'b1;
                        In_data     <= issue_word;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ISSUE: begin
                    state <= HELD;
`ifdef VFM_INPUT_SEQ_TAG_EN
                    seq_tag <= seq_tag + TAG_WIDTH'(1);
`endif
                end
                HELD: begin
                    if (strobe) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end
                end
                RELEASE_DB: begin
                    if (!strobe) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vfm_input_writer.sv
// Self-checking bench for vfm_input_writer with DEBOUNCE_CYCLES = 4.
// Honours VFM_INPUT_SEQ_TAG_EN when the build defines it.
module tb_vfm_input_writer;

    localparam int D = 4;
    localparam int W = 14;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   sw    = 5'h1F;
    logic [W-1:0] in_data;
    logic         input_write;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_data = '0;
    int           tag_cnt   = 0;
    int           write_cnt = 0;

    always #5 clk = ~clk;

    vfm_input_writer #(
        .DEBOUNCE_CYCLES (D),
        .IN_WIDTH        (W)
    ) dut (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .SW_in       (sw),
        .In_data     (in_data),
        .Input_write (input_write),
        .Busy        (busy)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Expected write word: valid marker + nibble*2 + tag*32 (tag only when enabled)
    function automatic logic [W-1:0] mk_word(input logic [3:0] nib, input int tag);
        int v;
        v = 1 + 2 * int'(nib);
`ifdef VFM_INPUT_SEQ_TAG_EN
        v = v + 32 * (tag % 512);
`else
        if (tag < 0) v = 0;
`endif
        return W'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic expect_write(input logic [3:0] nib);
        exp_q.push_back(mk_word(nib, tag_cnt));
        tag_cnt++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_data = '0;
        tag_cnt   = 0;
    endtask

    // One clock: sample #1 after the rising edge, check every write and data stability
    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (input_write === 1'b1) begin
            write_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write_data", 32'(in_data), 32'(e));
                last_data = e;
            end
        end else begin
            chk("data_hold", 32'(in_data), 32'(last_data));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_in_data", 32'(in_data), 32'd0);
        chk("rst_write", 32'(input_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        ticks(2);
        rst_n = 1'b1;
    endtask

    // Clean release from HELD; Busy must drop exactly D+3 edges after the release
    task automatic release_check(input string name);
        sw[4] = 1'b1;
        for (int k = 1; k <= D + 4; k++) begin
            tick();
            chk(name, 32'(busy), 32'(k < D + 3));
        end
    endtask

    initial begin
        int wc0;
        int accepted;
        logic [3:0] nib;

        // Reset state
        sw = 5'h1F;
        do_reset();
        ticks(3);
        chk("idle_busy", 32'(busy), 32'd0);

        // Clean press of 4'hA: write on edge D+3, Busy from edge 3
        wc0 = write_cnt;
        sw = {1'b0, 4'hA};
        expect_write(4'hA);
        for (int k = 1; k <= D + 5; k++) begin
            tick();
            chk("latency_write", 32'(input_write), 32'(k == D + 3));
            chk("press_busy", 32'(busy), 32'(k >= 3));
            if (k == D + 3) chk("first_word", 32'(in_data), 32'h0015);
        end
        // Nibble toggling while HELD must not disturb In_data
        for (int k = 0; k < 8; k++) begin
            sw[3:0] = ~sw[3:0];
            tick();
        end
        release_check("release_busy");
        chk("clean_press_count", 32'(write_cnt - wc0), 32'd1);

        // Short bounce: 2 low cycles, no write, back to idle
        wc0 = write_cnt;
        sw = {1'b0, 4'h5};
        ticks(2);
        sw[4] = 1'b1;
        ticks(6);
        chk("bounce_busy", 32'(busy), 32'd0);
        chk("bounce_count", 32'(write_cnt - wc0), 32'd0);

        // Boundary: D low cycles rejected, D+1 accepted
        wc0 = write_cnt;
        sw = {1'b0, 4'h9};
        ticks(D);
        sw[4] = 1'b1;
        ticks(6);
        chk("len_d_count", 32'(write_cnt - wc0), 32'd0);
        sw = {1'b0, 4'hC};
        expect_write(4'hC);
        ticks(D + 1);
        sw[4] = 1'b1;
        ticks(D + 6);
        chk("len_d1_count", 32'(write_cnt - wc0), 32'd1);
        chk("len_d1_busy", 32'(busy), 32'd0);

        // Release glitch of 2 cycles, then clean release: still one write
        wc0 = write_cnt;
        sw = {1'b0, 4'h3};
        expect_write(4'h3);
        ticks(D + 6);
        sw[4] = 1'b1;
        ticks(2);
        sw[4] = 1'b0;
        ticks(5);
        chk("glitch_busy", 32'(busy), 32'd1);
        release_check("glitch_release_busy");
        chk("glitch_count", 32'(write_cnt - wc0), 32'd1);

        // Reset at edge 5 of a press, button kept low through release
        wc0 = write_cnt;
        sw = {1'b0, 4'h6};
        ticks(5);
        do_reset();
        expect_write(4'h6);
        for (int k = 1; k <= D + 5; k++) begin
            tick();
            chk("post_reset_write", 32'(input_write), 32'(k == D + 3));
        end
        release_check("post_reset_release");
        chk("reset_press_count", 32'(write_cnt - wc0), 32'd1);

        // Random presses/bounces from a fresh reset: 513 accepted writes
        do_reset();
        ticks(2);
        wc0 = write_cnt;
        accepted = 0;
        while (accepted < 513) begin
            nib = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                sw = {1'b0, nib};
                ticks($urandom_range(1, D));
                sw[4] = 1'b1;
                ticks($urandom_range(1, 3));
            end else begin
                sw = {1'b0, nib};
                expect_write(nib);
                accepted++;
                ticks(D + 3);
                for (int k = $urandom_range(0, 4); k > 0; k--) begin
                    sw[3:0] = 4'($urandom_range(0, 15));
                    tick();
                end
                if ($urandom_range(0, 3) == 0) begin
                    sw[4] = 1'b1;
                    ticks($urandom_range(1, D));
                    sw = {1'b0, 4'($urandom_range(0, 15))};
                    ticks(2);
                end
                sw = {1'b1, 4'($urandom_range(0, 15))};
                ticks($urandom_range(D + 1, D + 3));
            end
        end
        ticks(D + 4);
        chk("random_write_count", 32'(write_cnt - wc0), 32'd513);
        chk("random_pending", 32'(exp_q.size()), 32'd0);
        chk("random_final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
